speed_sel_fsm: RTL and testbench

- Speed-selection controller for the toy dog.
- Turns two raw pushbuttons (faster/slower) and an obstacle sensor into a registered 2-bit speed code {A,B}.
- The speed code feeds the speed 7-segment display decoder directly downstream, and the motor stage.
- Sits between the board I/O pins and the display/motor path. Owns synchronisation, debouncing, press-edge detection and the speed state machine.

---
 rtl/speed_pkg.sv | 25 ++
 rtl/speed_sel_fsm_if.sv | 23 ++
 rtl/speed_sel_fsm_debounce_pulse.sv | 48 ++++
 rtl/speed_sel_fsm.sv | 98 +++++++++
 tb/tb_speed_sel_fsm.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/speed_pkg.sv
// Shared speed-selection types and speed-code constants, also used by the
// display decoder and motor stage.
package speed_pkg;

  typedef enum logic [1:0] {
    STOP    = 2'd0,
    SLOW    = 2'd1,
    FAST    = 2'd2,
    BLOCKED = 2'd3
  } speed_state_e;

  localparam logic [1:0] SPD_STOP = 2'b00;
  localparam logic [1:0] SPD_SLOW = 2'b01;
  localparam logic [1:0] SPD_FAST = 2'b10;

  // BLOCKED shows as a stopped dog, so code 2'b11 can never appear.
  function automatic logic [1:0] speed_code(input speed_state_e s);
    case (s)
      SLOW:    return SPD_SLOW;
      FAST:    return SPD_FAST;
      default: return SPD_STOP;
    endcase
  endfunction

endpackage

// File: rtl/speed_sel_fsm_if.sv
// Board-side signal bundle of the speed selector: raw buttons/sensor in,
// speed code and status flags out.
interface speed_sel_fsm_if;

  logic btn_up;
  logic btn_down;
  logic obstacle;
  logic A;
  logic B;
  logic moving;
  logic blocked;

  modport master (
    output btn_up, btn_down, obstacle,
    input  A, B, moving, blocked
  );

  modport slave (
    input  btn_up, btn_down, obstacle,
    output A, B, moving, blocked
  );

endinterface

// File: rtl/speed_sel_fsm_debounce_pulse.sv
// One pushbutton: 2-flop synchroniser, consecutive-cycle debounce and a
// one-cycle pulse on each accepted press (rising edge of the stable level).
module debounce_pulse #(
  parameter int DEB_CYCLES = 50000,
  parameter int CNT_W      = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments make every flop here sample pre-edge
  // values, which is what gives the synchroniser its two-stage depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Releases (falling edges of the stable level) produce nothing.
  assign pulse = stable & ~stable_d;

endmodule

// File: rtl/speed_sel_fsm.sv
// Speed-selection controller: turns debounced faster/slower presses and the
// obstacle sensor into the registered 2-bit speed code {A,B}.
module speed_sel_fsm
  import speed_pkg::*;
#(
  parameter int DEB_CYCLES  = 50000,
  parameter int HOLD_CYCLES = 25000000,
  parameter int CNT_W       = 25
) (
  input  logic            clk,
  input  logic            reset,
  speed_sel_fsm_if.slave  bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             up_pulse;
  logic             down_pulse;
  logic             obs_sync1;
  logic             obs_sync;
  logic [CNT_W-1:0] hold_cnt;
  logic             hold_done;
  speed_state_e     state;
  speed_state_e     next_state;

  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_up (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_up),
    .pulse (up_pulse)
  );

  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_down (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btn_down),
    .pulse (down_pulse)
  );

  // Obstacle is synchronised only: a single clean sample must stop the dog.
  always_ff @(posedge clk) begin
    if (reset) begin
      obs_sync1 <= 1'b0;
      obs_sync  <= 1'b0;
    end else begin
      obs_sync1 <= bus.obstacle;
      obs_sync  <= obs_sync1;
    end
  end

  assign hold_done = (state == BLOCKED) && !obs_sync && (hold_cnt == HOLD_LAST);

  // Hold counter lives only in BLOCKED and restarts on any obstacle sample.
  always_ff @(posedge clk) begin
    if (reset || (state != BLOCKED) || obs_sync || hold_done) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= STOP;
    else       state <= next_state;
  end

  // NOTE: next_state gets its default before any branch, so every path
  // assigns it and no latch is inferred.
  always_comb begin
    next_state = state;
    if (obs_sync) begin
      next_state = BLOCKED;
    end else if (state == BLOCKED) begin
      if (hold_done) next_state = STOP;
    end else if (up_pulse ^ down_pulse) begin
      if (up_pulse) begin
        case (state)
          STOP:    next_state = SLOW;
          SLOW:    next_state = FAST;
          default: next_state = state;
        endcase
      end else begin
        case (state)
          FAST:    next_state = SLOW;
          SLOW:    next_state = STOP;
          default: next_state = state;
        endcase
      end
    end
  end

  always_comb begin
    {bus.A, bus.B} = speed_code(state);
    bus.moving     = (state == SLOW) || (state == FAST);
    bus.blocked    = (state == BLOCKED);
  end

endmodule

// File: tb/tb_speed_sel_fsm.sv
// Self-checking bench for speed_sel_fsm with DEB_CYCLES=4, HOLD_CYCLES=8.
module tb_speed_sel_fsm;

  // Expected {A,B,moving,blocked} per state.
  localparam logic [3:0] E_STOP = 4'b0000;
  localparam logic [3:0] E_SLOW = 4'b0110;
  localparam logic [3:0] E_FAST = 4'b1010;
  localparam logic [3:0] E_BLK  = 4'b0001;

  typedef struct {
    logic       rst;
    logic       up;
    logic       down;
    logic       obs;
    int         n;
    logic [3:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  vec_t tbl[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  speed_sel_fsm_if bus ();

  speed_sel_fsm #(
    .DEB_CYCLES  (4),
    .HOLD_CYCLES (8),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic add(input logic rst, input logic up, input logic down, input logic obs,
                     input int n, input logic [3:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.up = up; v.down = down; v.obs = obs;
    v.n = n; v.exp = exp; v.name = name;
    tbl.push_back(v);
  endtask

  // A clean press: held 6 cycles (old state throughout), released 10 cycles
  // (new state from the first released edge onward).
  task automatic add_press(input logic up, input logic down, input logic [3:0] old_e,
                           input logic [3:0] new_e, input string name);
    add(1'b0, up, down, 1'b0, 6, old_e, {name, "_held"});
    add(1'b0, 1'b0, 1'b0, 1'b0, 10, new_e, {name, "_rel"});
  endtask

  // Drive one input pattern for n cycles; the expected outputs after each of
  // those rising edges go into the scoreboard.
  task automatic run(input logic rst, input logic up, input logic down, input logic obs,
                     input int n, input logic [3:0] exp, input string name);
    sb_t e;
    repeat (n) begin
      @(negedge clk);
      reset        = rst;
      bus.btn_up   = up;
      bus.btn_down = down;
      bus.obstacle = obs;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic press(input logic up, input logic down, input logic [3:0] old_e,
                       input logic [3:0] new_e, input string name);
    run(1'b0, up, down, 1'b0, 6, old_e, {name, "_held"});
    run(1'b0, 1'b0, 1'b0, 1'b0, 10, new_e, {name, "_rel"});
  endtask

  // Scoreboard consumer: compares just after every rising edge.
  initial begin
    sb_t        e;
    logic [3:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.A, bus.B, bus.moving, bus.blocked};
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s @%0t: {A,B,moving,blocked} got %b want %b", e.name, $time, act, e.exp);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.obstacle = 1'b0;

    // Reset state and idle.
    add(1'b1, 1'b0, 1'b0, 1'b0, 2, E_STOP, "reset");
    add(1'b0, 1'b0, 1'b0, 1'b0, 20, E_STOP, "idle");
    // Press latency: held from edge N, code changes exactly at edge N+6.
    add(1'b0, 1'b1, 1'b0, 1'b0, 6, E_STOP, "up_lat_pre");
    add(1'b0, 1'b1, 1'b0, 1'b0, 4, E_SLOW, "up_lat_post");
    add(1'b0, 1'b0, 1'b0, 1'b0, 10, E_SLOW, "up_release");
    add_press(1'b0, 1'b1, E_SLOW, E_STOP, "dn_restore1");
    // Bouncing: runs of 2 never reach 4 stable cycles; only the final hold counts.
    add(1'b0, 1'b1, 1'b0, 1'b0, 2, E_STOP, "bounce_hi1");
    add(1'b0, 1'b0, 1'b0, 1'b0, 2, E_STOP, "bounce_lo1");
    add(1'b0, 1'b1, 1'b0, 1'b0, 2, E_STOP, "bounce_hi2");
    add(1'b0, 1'b0, 1'b0, 1'b0, 2, E_STOP, "bounce_lo2");
    add_press(1'b1, 1'b0, E_STOP, E_SLOW, "bounce_hold");
    add_press(1'b0, 1'b1, E_SLOW, E_STOP, "dn_restore2");
    // Step up with saturation, then down with saturation.
    add_press(1'b1, 1'b0, E_STOP, E_SLOW, "up1");
    add_press(1'b1, 1'b0, E_SLOW, E_FAST, "up2");
    add_press(1'b1, 1'b0, E_FAST, E_FAST, "up3_sat");
    add_press(1'b0, 1'b1, E_FAST, E_SLOW, "dn1");
    add_press(1'b0, 1'b1, E_SLOW, E_STOP, "dn2");
    add_press(1'b0, 1'b1, E_STOP, E_STOP, "dn3_sat");

    for (int i = 0; i < tbl.size(); i++)
      run(tbl[i].rst, tbl[i].up, tbl[i].down, tbl[i].obs, tbl[i].n, tbl[i].exp, tbl[i].name);

    // Obstacle from FAST; raw assertion sampled at edge M.
    press(1'b1, 1'b0, E_STOP, E_SLOW, "obs_prep1");
    press(1'b1, 1'b0, E_SLOW, E_FAST, "obs_prep2");
    run(1'b0, 1'b1, 1'b0, 1'b1, 2, E_FAST, "obs_pre");        // M, M+1
    run(1'b0, 1'b1, 1'b0, 1'b1, 3, E_BLK,  "obs_blocked");    // M+2..M+4
    run(1'b0, 1'b1, 1'b0, 1'b0, 1, E_BLK,  "obs_up_ign");     // M+5 (pulse dropped)
    run(1'b0, 1'b0, 1'b0, 1'b0, 4, E_BLK,  "obs_clear5");     // M+6..M+9
    run(1'b0, 1'b0, 1'b0, 1'b1, 1, E_BLK,  "obs_blip");       // M+10 (clears hold)
    run(1'b0, 1'b1, 1'b0, 1'b0, 6, E_BLK,  "obs_hold_up");    // M+11..M+16
    run(1'b0, 1'b0, 1'b0, 1'b0, 3, E_BLK,  "obs_hold_end");   // M+17..M+19
    run(1'b0, 1'b0, 1'b0, 1'b0, 10, E_STOP, "obs_exit");      // M+20 onward

    // Simultaneous presses from SLOW.
    press(1'b1, 1'b0, E_STOP, E_SLOW, "both_prep");
    press(1'b1, 1'b1, E_SLOW, E_SLOW, "both");

    // Reset during a 2-cycle-old press, button released at reset.
    run(1'b0, 1'b1, 1'b0, 1'b0, 2, E_SLOW, "rst_mid_pre");
    run(1'b1, 1'b0, 1'b0, 1'b0, 1, E_STOP, "rst_mid");
    run(1'b0, 1'b0, 1'b0, 1'b0, 12, E_STOP, "rst_no_step");

    // Reset during a 2-cycle-old press, button kept held: full re-debounce.
    run(1'b0, 1'b1, 1'b0, 1'b0, 2, E_STOP, "rst_hold_pre");
    run(1'b1, 1'b1, 1'b0, 1'b0, 1, E_STOP, "rst_hold");
    run(1'b0, 1'b1, 1'b0, 1'b0, 6, E_STOP, "rst_redeb");
    run(1'b0, 1'b0, 1'b0, 1'b0, 10, E_SLOW, "rst_redeb_step");

    @(posedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
